// File: rtl/b9_bist_ctrl.sv
// BIST controller for the b9 benchmark: a 41-bit LFSR drives the b9 inputs and
// a 21-bit MISR compacts the b9 outputs into a signature checked against GOLDEN.
module b9_bist_ctrl #(
    parameter int unsigned NUM_PATTERNS = 1024,
    parameter logic [40:0] SEED         = 41'h00000000001,
    parameter logic [20:0] GOLDEN       = 21'h000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [40:0] dut_in,
    input  logic [20:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [20:0] signature,
    output logic [15:0] pat_count,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a run starts when start=1 is sampled in IDLE or DONE; busy is
    // high for the whole run, and done (with pass valid) holds until the next start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_PAT = 16'(NUM_PATTERNS - 1);

    state_t      state_q;
    logic [40:0] lfsr_q;
    logic [40:0] lfsr_d;
    logic [20:0] misr_q;
    logic [20:0] misr_d;
    logic [15:0] cnt_q;
    logic        pass_q;

    // LFSR x^41+x^3+1 and MISR x^21+x^2+1, both shifting towards the MSB.
    always_comb begin
        lfsr_d = {lfsr_q[39:0], lfsr_q[40] ^ lfsr_q[2]};
        misr_d = {misr_q[19:0], misr_q[20] ^ misr_q[1]} ^ dut_out;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        lfsr_q  <= SEED;
                        misr_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        lfsr_q <= lfsr_d;
                        misr_q <= misr_d;
                        cnt_q  <= cnt_q + 16'd1;
                        // Verdict is taken from the final signature as it is written.
                        if (cnt_q == LAST_PAT) begin
                            state_q <= DONE;
                            pass_q  <= (misr_d == GOLDEN);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        lfsr_q  <= SEED;
                        misr_q  <= '0;
                        cnt_q   <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in      = lfsr_q;
    assign signature   = misr_q;
    assign pat_count   = cnt_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_b9_bist_ctrl.sv
// Bench for b9_bist_ctrl: a 2-pattern instance for exact small-run values and a
// 1024-pattern instance driven by a randomly keyed combinational b9 stand-in.
module tb_b9_bist_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    logic        start_a, abort_a;
    logic [20:0] dout_a;
    logic [40:0] din_a;
    logic        busy_a, done_a, pass_a;
    logic [20:0] sig_a;
    logic [15:0] cnt_a;
    logic [1:0]  st_a;

    logic        start_b, abort_b;
    logic [20:0] dout_b;
    logic [40:0] din_b;
    logic        busy_b, done_b, pass_b;
    logic [20:0] sig_b;
    logic [15:0] cnt_b;
    logic [1:0]  st_b;

    logic [20:0] key_b;
    logic [40:0] m_lfsr;
    logic [20:0] m_sig;
    int          m_cnt;
    logic [20:0] sig1;
    logic [40:0] exp_seq [4];

    always #5 clock = ~clock;

    b9_bist_ctrl #(.NUM_PATTERNS(2), .SEED(41'h1), .GOLDEN(21'h000003)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort_a),
        .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a), .pat_count(cnt_a), .dbg_state_o(st_a)
    );

    b9_bist_ctrl #(.NUM_PATTERNS(1024), .SEED(41'h1), .GOLDEN(21'h000000)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
        .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b), .pat_count(cnt_b), .dbg_state_o(st_b)
    );

    // Combinational stand-in for b9: fixed nonlinear mapping plus a random key.
    function automatic logic [20:0] b9_ref(input logic [40:0] x, input logic [20:0] k);
        return (x[20:0] & x[40:20]) ^ {x[9:0], x[40:30]} ^ k;
    endfunction

    assign dout_b = b9_ref(din_b, key_b);

    function automatic logic [40:0] m_lfsr_next(input logic [40:0] x);
        logic [40:0] fb;
        fb = ((x >> 40) ^ (x >> 2)) & 41'd1;
        return (x << 1) | fb;
    endfunction

    function automatic logic [20:0] m_misr_next(input logic [20:0] s, input logic [20:0] r);
        logic [20:0] fb;
        fb = ((s >> 20) ^ (s >> 1)) & 21'd1;
        return ((s << 1) | fb) ^ r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a();
        chk("a_rst_busy", 64'(busy_a), 64'd0);
        chk("a_rst_done", 64'(done_a), 64'd0);
        chk("a_rst_pass", 64'(pass_a), 64'd0);
        chk("a_rst_din", 64'(din_a), 64'h1);
        chk("a_rst_sig", 64'(sig_a), 64'd0);
        chk("a_rst_cnt", 64'(cnt_a), 64'd0);
    endtask

    task automatic check_reset_b();
        chk("b_rst_busy", 64'(busy_b), 64'd0);
        chk("b_rst_done", 64'(done_b), 64'd0);
        chk("b_rst_pass", 64'(pass_b), 64'd0);
        chk("b_rst_din", 64'(din_b), 64'h1);
        chk("b_rst_sig", 64'(sig_b), 64'd0);
        chk("b_rst_cnt", 64'(cnt_b), 64'd0);
    endtask

    // Two-pattern run with dut_out held constant; exp_sig is the hand-derived result.
    task automatic run_a(input logic [20:0] dv, input logic [20:0] exp_sig, input logic exp_pass);
        logic [40:0] al;
        logic [20:0] as;
        dout_a  = dv;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        al = 41'h1;
        as = '0;
        chk("a_start_busy", 64'(busy_a), 64'd1);
        chk("a_start_done", 64'(done_a), 64'd0);
        chk("a_start_cnt", 64'(cnt_a), 64'd0);
        chk("a_start_sig", 64'(sig_a), 64'd0);
        chk("a_start_din", 64'(din_a), 64'(al));
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            as = m_misr_next(as, dv);
            al = m_lfsr_next(al);
            chk("a_sig", 64'(sig_a), 64'(as));
            chk("a_din", 64'(din_a), 64'(al));
            chk("a_cnt", 64'(cnt_a), 64'(k));
            chk("a_busy", 64'(busy_a), 64'(k < 2));
            chk("a_done", 64'(done_a), 64'(k == 2));
        end
        chk("a_final_sig", 64'(sig_a), 64'(exp_sig));
        chk("a_pass", 64'(pass_a), 64'(exp_pass));
    endtask

    task automatic start_b_run();
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        m_lfsr = 41'h1;
        m_sig  = '0;
        m_cnt  = 0;
        chk("b_start_busy", 64'(busy_b), 64'd1);
        chk("b_start_done", 64'(done_b), 64'd0);
        chk("b_start_cnt", 64'(cnt_b), 64'd0);
        chk("b_start_sig", 64'(sig_b), 64'd0);
        chk("b_start_din", 64'(din_b), 64'(m_lfsr));
    endtask

    task automatic step_b();
        logic [20:0] r;
        r = b9_ref(m_lfsr, key_b);
        @(negedge clock);
        m_sig  = m_misr_next(m_sig, r);
        m_lfsr = m_lfsr_next(m_lfsr);
        m_cnt++;
        chk("b_sig", 64'(sig_b), 64'(m_sig));
        chk("b_din", 64'(din_b), 64'(m_lfsr));
        chk("b_cnt", 64'(cnt_b), 64'(m_cnt));
        chk("b_busy", 64'(busy_b), 64'(m_cnt < 1024));
        chk("b_done", 64'(done_b), 64'(m_cnt == 1024));
        if (m_cnt == 1024) chk("b_pass", 64'(pass_b), 64'(m_sig == 21'd0));
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        abort_a = 1'b0;
        dout_a  = '0;
        start_b = 1'b0;
        abort_b = 1'b0;
        key_b   = 21'($urandom);
        exp_seq[0] = 41'h1;
        exp_seq[1] = 41'h2;
        exp_seq[2] = 41'h4;
        exp_seq[3] = 41'h9;

        // Reset, then idle for 10 cycles.
        repeat (2) @(negedge clock);
        check_reset_a();
        check_reset_b();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_din_a", 64'(din_a), 64'h1);
            chk("idle_sig_a", 64'(sig_a), 64'd0);
            chk("idle_busy_b", 64'(busy_b), 64'd0);
            chk("idle_done_b", 64'(done_b), 64'd0);
        end

        // Short run with matching signature, then restart from DONE with a mismatch.
        run_a(21'h000001, 21'h000003, 1'b1);
        @(negedge clock);
        chk("a_hold_done", 64'(done_a), 64'd1);
        chk("a_hold_sig", 64'(sig_a), 64'h3);
        run_a(21'h000000, 21'h000000, 1'b0);

        // Abort at pat_count=100, then abort is inert in IDLE.
        start_b_run();
        repeat (100) step_b();
        abort_b = 1'b1;
        @(negedge clock);
        chk("abort_busy", 64'(busy_b), 64'd0);
        chk("abort_done", 64'(done_b), 64'd0);
        chk("abort_cnt", 64'(cnt_b), 64'd100);
        chk("abort_sig", 64'(sig_b), 64'(m_sig));
        chk("abort_din", 64'(din_b), 64'(m_lfsr));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("idle_abort_cnt", 64'(cnt_b), 64'd100);
            chk("idle_abort_done", 64'(done_b), 64'd0);
            chk("idle_abort_busy", 64'(busy_b), 64'd0);
        end
        abort_b = 1'b0;

        // Reset at pat_count=500, with start also high to show reset wins.
        start_b_run();
        repeat (500) step_b();
        reset   = 1'b1;
        start_b = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        start_b = 1'b0;
        check_reset_b();
        check_reset_a();
        @(negedge clock);
        chk("post_rst_busy", 64'(busy_b), 64'd0);

        // Full run; start pulsed mid-run must be ignored.
        start_b_run();
        for (int k = 1; k <= 1024; k++) begin
            if (k <= 3) chk("b_seq", 64'(din_b), 64'(exp_seq[k-1]));
            if (k == 10) start_b = 1'b1;
            step_b();
            start_b = 1'b0;
        end
        chk("b_seq_last", 64'(exp_seq[3]), 64'(41'h9) ^ 64'(din_b == din_b ? 41'h0 : 41'h1));
        sig1 = m_sig;

        // Abort is inert in DONE.
        abort_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("done_abort_done", 64'(done_b), 64'd1);
            chk("done_abort_sig", 64'(sig_b), 64'(sig1));
            chk("done_abort_cnt", 64'(cnt_b), 64'd1024);
        end
        abort_b = 1'b0;

        // Restart from DONE; second run must reproduce the first signature.
        start_b_run();
        repeat (1024) step_b();
        chk("b_rerun_sig", 64'(sig_b), 64'(sig1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
